// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register feeding the MEM stage.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_next_i,
  input  logic [31:0] r1_data_i,
  input  logic [31:0] r2_data_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  writebackaddr_i,
  input  logic        stall_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        valid_o_mem,
  output logic [31:0] alu_result_o_mem,
  output logic [31:0] store_data_o_mem,
  output logic [31:0] instr_o_mem,
  output logic [4:0]  writebackaddr_o_mem,
  output logic        is_load_o_mem
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic        valid_q, valid_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic        is_load_q, is_load_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, result, target;
  logic        known, take, is_load, rd_zero, fire;

  // EX/MEM wins over WB; a load in EX/MEM has no data yet, so it is skipped.
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf,
                                      input logic mem_v, input logic mem_ld,
                                      input logic [4:0] mem_rd, input logic [31:0] mem_val,
                                      input logic wb_we, input logic [4:0] wb_rd,
                                      input logic [31:0] wb_val);
    if (rs == 5'd0)                               return rf;
    else if (mem_v && !mem_ld && mem_rd == rs)    return mem_val;
    else if (wb_we && wb_rd == rs)                return wb_val;
    else                                          return rf;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] a_s, b_s;
    logic [4:0]         sh;
    a_s = a;
    b_s = b;
    sh  = b[4:0];
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return {31'd0, a_s < b_s};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return alt ? $unsigned(a_s >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic br_cond(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    logic signed [31:0] a_s, b_s;
    a_s = a;
    b_s = b;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return a_s < b_s;
      3'd5:    return a_s >= b_s;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign fire   = valid_i & ~stall_i;

  always_comb begin
    rs1_val = fwd(instr_i[19:15], r1_data_i, valid_q, is_load_q, wb_addr_q, alu_result_q,
                  wb_we_i, wb_addr_i, wb_data_i);
    rs2_val = fwd(instr_i[24:20], r2_data_i, valid_q, is_load_q, wb_addr_q, alu_result_q,
                  wb_we_i, wb_addr_i, wb_data_i);
    result  = 32'd0;
    target  = pc_i + imm_i;
    known   = 1'b1;
    take    = 1'b0;
    is_load = 1'b0;
    rd_zero = 1'b0;
    case (opcode)
      OP_REG:    result = alu(funct3, instr_i[30], rs1_val, rs2_val);
      OP_IMM:    result = alu(funct3, (funct3 == 3'd5) & instr_i[30], rs1_val, imm_i);
      OP_LUI:    result = imm_i;
      OP_AUIPC:  result = pc_i + imm_i;
      OP_LOAD: begin
        result  = rs1_val + imm_i;
        is_load = 1'b1;
      end
      OP_STORE: begin
        result  = rs1_val + imm_i;
        rd_zero = 1'b1;
      end
      OP_JAL: begin
        result = pc_next_i;
        take   = 1'b1;
      end
      OP_JALR: begin
        result = pc_next_i;
        target = (rs1_val + imm_i) & ~32'd1;
        take   = 1'b1;
      end
      OP_BRANCH: begin
        take    = br_cond(funct3, rs1_val, rs2_val);
        rd_zero = 1'b1;
      end
      default:   known = 1'b0;
    endcase

    redirect_o    = fire & take & ~rst;
    redirect_pc_o = redirect_o ? target : 32'd0;

    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    instr_d      = instr_q;
    wb_addr_d    = wb_addr_q;
    is_load_d    = is_load_q;
    if (!stall_i) begin
      valid_d      = valid_i & known;
      alu_result_d = result;
      store_data_d = rs2_val;
      instr_d      = instr_i;
      wb_addr_d    = rd_zero ? 5'd0 : writebackaddr_i;
      is_load_d    = is_load;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      alu_result_q <= 32'd0;
      store_data_q <= 32'd0;
      instr_q      <= 32'd0;
      wb_addr_q    <= 5'd0;
      is_load_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      instr_q      <= instr_d;
      wb_addr_q    <= wb_addr_d;
      is_load_q    <= is_load_d;
    end
  end

  assign valid_o_mem         = valid_q;
  assign alu_result_o_mem    = alu_result_q;
  assign store_data_o_mem    = store_data_q;
  assign instr_o_mem         = instr_q;
  assign writebackaddr_o_mem = wb_addr_q;
  assign is_load_o_mem       = is_load_q;

endmodule
